// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer
// Two-requester round-robin front end for the shared 12-bit combinational ALU.
// A granted request's operands are latched onto the ALU inputs and held for a
// programmable settle time. The result and flags are then captured and
// returned with the requester ID over a valid/ready response channel.
// Only one operation is in flight at a time.
module alu_req_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [11:0]      req0_a,
    input  logic [11:0]      req0_b,
    input  logic [3:0]       req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [11:0]      req1_a,
    input  logic [11:0]      req1_b,
    input  logic [3:0]       req1_sel,

    output logic [11:0]      alu_a,
    output logic [11:0]      alu_b,
    output logic [3:0]       alu_sel,
    input  logic [11:0]      alu_result,
    input  logic             alu_agrtb,
    input  logic             alu_altb,
    input  logic             alu_aeqb,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [11:0]      rsp_result,
    output logic             rsp_agrtb,
    output logic             rsp_altb,
    output logic             rsp_aeqb,

    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam int DATA_W = 12;
    localparam int SEL_W  = 4;

    // A settle time below one cycle is treated as one cycle.
    localparam int          HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                     last_grant;
    logic                     grant;
    logic                     grant_vld;
    logic                     accept;
    logic [15:0]              hold_cnt;
    logic                     hold_done;

    logic signed [DATA_W-1:0] mux_a;
    logic signed [DATA_W-1:0] mux_b;
    logic        [SEL_W-1:0]  mux_sel;

    // Round-robin grant: a lone requester wins; on contention the one that
    // was not granted last time wins.
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (req0_valid && req1_valid) begin
            grant     = ~last_grant;
            grant_vld = 1'b1;
        end else if (req0_valid) begin
            grant     = 1'b0;
            grant_vld = 1'b1;
        end else if (req1_valid) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end
    end

    // Ready only in IDLE and only toward the granted requester, so at most
    // one ready is ever high and an accept happens exactly when it is.
    always_comb begin
        req0_ready = (state_q == IDLE) && grant_vld && !grant;
        req1_ready = (state_q == IDLE) && grant_vld &&  grant;
        accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    end

    // Operand selection for the granted requester.
    always_comb begin
        mux_a   = grant ? req1_a   : req0_a;
        mux_b   = grant ? req1_b   : req0_b;
        mux_sel = grant ? req1_sel : req0_sel;
    end

    assign hold_done = (hold_cnt == 16'd0);
    assign busy      = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept -> settle -> respond -> idle, no bypass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (hold_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue stage: latch operands onto the ALU on accept; they stay put until
    // the next accept so the ALU sees stable inputs throughout the settle time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            hold_cnt   <= 16'd0;
        end else begin
            if (state_q == IDLE && accept) begin
                alu_a      <= mux_a;
                alu_b      <= mux_b;
                alu_sel    <= mux_sel;
                rsp_id     <= grant;
                last_grant <= grant;
                hold_cnt   <= HOLD_LOAD;
            end else if (state_q == SETTLE && !hold_done) begin
                hold_cnt   <= hold_cnt - 16'd1;
            end
        end
    end

    // Capture stage: sample the ALU once the settle time has elapsed and hold
    // the response until the consumer takes it. The captured result and flags
    // persist after the handshake completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_agrtb  <= 1'b0;
            rsp_altb   <= 1'b0;
            rsp_aeqb   <= 1'b0;
        end else begin
            if (state_q == SETTLE && hold_done) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_agrtb  <= alu_agrtb;
                rsp_altb   <= alu_altb;
                rsp_aeqb   <= alu_aeqb;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    // Completed-response counter, wraps at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (state_q == RESP && rsp_ready) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed bench for alu_req_sequencer. Two instances share the requester
// inputs: u_dut1 (one-cycle settle, 4-bit counter) and u_dut3 (three-cycle
// settle, 16-bit counter). Each is paired with its own behavioural ALU.
module tb_alu_req_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [11:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        rsp_ready;

    logic        req0_ready_1, req1_ready_1, req0_ready_3, req1_ready_3;
    logic [11:0] alu_a_1, alu_b_1, alu_a_3, alu_b_3;
    logic [3:0]  alu_sel_1, alu_sel_3;
    logic [11:0] alu_result_1, alu_result_3;
    logic        alu_agrtb_1, alu_altb_1, alu_aeqb_1;
    logic        alu_agrtb_3, alu_altb_3, alu_aeqb_3;
    logic        rsp_valid_1, rsp_id_1, rsp_agrtb_1, rsp_altb_1, rsp_aeqb_1, busy_1;
    logic        rsp_valid_3, rsp_id_3, rsp_agrtb_3, rsp_altb_3, rsp_aeqb_3, busy_3;
    logic [11:0] rsp_result_1, rsp_result_3;
    logic [3:0]  ops_done_1;
    logic [15:0] ops_done_3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: 0100 add, 0101 subtract, 0011 pass a; flags signed.
    function automatic logic [14:0] alu_model(input logic [11:0] a,
                                              input logic [11:0] b,
                                              input logic [3:0]  sel);
        logic [11:0] r;
        case (sel)
            4'b0100: r = a + b;
            4'b0101: r = a - b;
            4'b0011: r = a;
            default: r = '0;
        endcase
        return {($signed(a) > $signed(b)), ($signed(a) < $signed(b)), (a == b), r};
    endfunction

    assign {alu_agrtb_1, alu_altb_1, alu_aeqb_1, alu_result_1} = alu_model(alu_a_1, alu_b_1, alu_sel_1);
    assign {alu_agrtb_3, alu_altb_3, alu_aeqb_3, alu_result_3} = alu_model(alu_a_3, alu_b_3, alu_sel_3);

    alu_req_sequencer #(.HOLD_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_1),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready_1),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a_1), .alu_b(alu_b_1), .alu_sel(alu_sel_1),
        .alu_result(alu_result_1), .alu_agrtb(alu_agrtb_1),
        .alu_altb(alu_altb_1), .alu_aeqb(alu_aeqb_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_id(rsp_id_1),
        .rsp_result(rsp_result_1), .rsp_agrtb(rsp_agrtb_1),
        .rsp_altb(rsp_altb_1), .rsp_aeqb(rsp_aeqb_1),
        .busy(busy_1), .ops_done(ops_done_1)
    );

    alu_req_sequencer #(.HOLD_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_3),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready_3),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_sel(alu_sel_3),
        .alu_result(alu_result_3), .alu_agrtb(alu_agrtb_3),
        .alu_altb(alu_altb_3), .alu_aeqb(alu_aeqb_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready), .rsp_id(rsp_id_3),
        .rsp_result(rsp_result_3), .rsp_agrtb(rsp_agrtb_3),
        .rsp_altb(rsp_altb_3), .rsp_aeqb(rsp_aeqb_3),
        .busy(busy_3), .ops_done(ops_done_3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          nrsp;
        logic        both_rdy;
        logic [11:0] got_res [4];
        logic        got_id  [4];

        rst_n = 1'b1; rsp_ready = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_a = 0; req1_b = 0; req1_sel = 0;

        // Reset state
        do_reset();
        chk("rst_busy",   32'(busy_1), 0);
        chk("rst_rspv",   32'(rsp_valid_1), 0);
        chk("rst_ops",    32'(ops_done_1), 0);
        chk("rst_alu_a",  32'(alu_a_1), 0);
        chk("rst_alu_sel", 32'(alu_sel_1), 0);
        chk("rst_result", 32'(rsp_result_1), 0);
        chk("rst_id",     32'(rsp_id_1), 0);
        chk("rst_ops3",   32'(ops_done_3), 0);

        // req0: 5 + 3
        req0_valid = 1; req0_a = 12'h005; req0_b = 12'h003; req0_sel = 4'b0100;
        #1;
        chk("add_r0rdy", 32'(req0_ready_1), 1);
        chk("add_r1rdy", 32'(req1_ready_1), 0);
        tick();
        req0_valid = 0;
        chk("add_busy",  32'(busy_1), 1);
        chk("add_alu_a", 32'(alu_a_1), 12'h005);
        chk("add_alu_b", 32'(alu_b_1), 12'h003);
        chk("add_sel",   32'(alu_sel_1), 4'b0100);
        chk("add_rspv0", 32'(rsp_valid_1), 0);
        chk("add_r0rdy_settle", 32'(req0_ready_1), 0);
        tick();
        chk("add_rspv",  32'(rsp_valid_1), 1);
        chk("add_res",   32'(rsp_result_1), 12'h008);
        chk("add_gt",    32'(rsp_agrtb_1), 1);
        chk("add_lt",    32'(rsp_altb_1), 0);
        chk("add_eq",    32'(rsp_aeqb_1), 0);
        chk("add_id",    32'(rsp_id_1), 0);
        tick();
        chk("add_rspv_drop", 32'(rsp_valid_1), 0);
        chk("add_ops",   32'(ops_done_1), 1);
        chk("add_idle",  32'(busy_1), 0);
        chk("add_res_hold", 32'(rsp_result_1), 12'h008);

        // req1: 3 - 5
        req1_valid = 1; req1_a = 12'h003; req1_b = 12'h005; req1_sel = 4'b0101;
        #1;
        chk("sub_r1rdy", 32'(req1_ready_1), 1);
        chk("sub_r0rdy", 32'(req0_ready_1), 0);
        tick();
        req1_valid = 0;
        tick();
        chk("sub_rspv", 32'(rsp_valid_1), 1);
        chk("sub_res",  32'(rsp_result_1), 12'hFFE);
        chk("sub_lt",   32'(rsp_altb_1), 1);
        chk("sub_gt",   32'(rsp_agrtb_1), 0);
        chk("sub_id",   32'(rsp_id_1), 1);
        tick();
        chk("sub_ops",  32'(ops_done_1), 2);

        // req0: 7 + 7, equal operands
        req0_valid = 1; req0_a = 12'h007; req0_b = 12'h007; req0_sel = 4'b0100;
        tick();
        req0_valid = 0;
        tick();
        chk("eq_res", 32'(rsp_result_1), 12'h00E);
        chk("eq_eq",  32'(rsp_aeqb_1), 1);
        chk("eq_lt",  32'(rsp_altb_1), 0);
        tick();

        // Both requesters valid every cycle after reset: alternate 0,1,0,1
        do_reset();
        req0_a = 12'h111; req0_b = 12'h000; req0_sel = 4'b0011;
        req1_a = 12'h222; req1_b = 12'h000; req1_sel = 4'b0011;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        nrsp = 0; both_rdy = 0;
        for (int i = 0; i < 14; i++) begin
            if (req0_ready_1 && req1_ready_1) both_rdy = 1;
            tick();
            if (rsp_valid_1 && nrsp < 4) begin
                got_res[nrsp] = rsp_result_1;
                got_id[nrsp]  = rsp_id_1;
                nrsp++;
            end
        end
        req0_valid = 0; req1_valid = 0;
        chk("rr_count", 32'(nrsp), 4);
        chk("rr_both_ready", 32'(both_rdy), 0);
        chk("rr_id0", 32'(got_id[0]), 0);
        chk("rr_id1", 32'(got_id[1]), 1);
        chk("rr_id2", 32'(got_id[2]), 0);
        chk("rr_id3", 32'(got_id[3]), 1);
        chk("rr_res0", 32'(got_res[0]), 12'h111);
        chk("rr_res1", 32'(got_res[1]), 12'h222);
        chk("rr_res2", 32'(got_res[2]), 12'h111);
        chk("rr_res3", 32'(got_res[3]), 12'h222);
        tick(); tick(); tick();
        chk("rr_ops", 32'(ops_done_1), 5);

        // Response backpressure for 5 cycles with req0 waiting
        rsp_ready = 0;
        req0_valid = 1; req0_a = 12'h123; req0_b = 12'h001; req0_sel = 4'b0100;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv",  32'(rsp_valid_1), 1);
            chk("bp_res",   32'(rsp_result_1), 12'h124);
            chk("bp_gt",    32'(rsp_agrtb_1), 1);
            chk("bp_busy",  32'(busy_1), 1);
            chk("bp_r0rdy", 32'(req0_ready_1), 0);
            tick();
        end
        rsp_ready = 1;
        tick();
        chk("bp_rel_busy",  32'(busy_1), 0);
        chk("bp_rel_rspv",  32'(rsp_valid_1), 0);
        chk("bp_rel_r0rdy", 32'(req0_ready_1), 1);
        chk("bp_rel_hold",  32'(rsp_result_1), 12'h124);
        tick();
        chk("bp_reaccept", 32'(busy_1), 1);
        chk("bp_reaccept_a", 32'(alu_a_1), 12'h123);
        req0_valid = 0;
        tick(); tick();

        // 16 ops wrap the 4-bit counter
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 12'h001; req0_b = 12'h001; req0_sel = 4'b0100;
        repeat (45) tick();
        chk("wrap_15", 32'(ops_done_1), 15);
        repeat (3) tick();
        chk("wrap_0", 32'(ops_done_1), 0);
        req0_valid = 0;

        // Three-cycle settle on u_dut3
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 12'h010; req0_b = 12'h020; req0_sel = 4'b0100;
        #1;
        chk("h3_r0rdy", 32'(req0_ready_3), 1);
        chk("h3_r1rdy", 32'(req1_ready_3), 0);
        tick();
        req0_valid = 0; req0_a = 12'h7FF; req0_b = 12'h000; req0_sel = 4'b0000;
        chk("h3_a_k0",  32'(alu_a_3), 12'h010);
        chk("h3_b_k0",  32'(alu_b_3), 12'h020);
        chk("h3_sel_k0", 32'(alu_sel_3), 4'b0100);
        chk("h3_rspv_k0", 32'(rsp_valid_3), 0);
        chk("h3_busy",  32'(busy_3), 1);
        tick();
        chk("h3_rspv_k1", 32'(rsp_valid_3), 0);
        chk("h3_a_k1",  32'(alu_a_3), 12'h010);
        tick();
        chk("h3_rspv_k2", 32'(rsp_valid_3), 0);
        chk("h3_b_k2",  32'(alu_b_3), 12'h020);
        chk("h3_sel_k2", 32'(alu_sel_3), 4'b0100);
        tick();
        chk("h3_rspv_k3", 32'(rsp_valid_3), 1);
        chk("h3_res",   32'(rsp_result_3), 12'h030);
        chk("h3_lt",    32'(rsp_altb_3), 1);
        chk("h3_gt",    32'(rsp_agrtb_3), 0);
        chk("h3_eq",    32'(rsp_aeqb_3), 0);
        chk("h3_id",    32'(rsp_id_3), 0);
        tick();
        chk("h3_ops",   32'(ops_done_3), 1);
        chk("h3_drop",  32'(rsp_valid_3), 0);

        // req1 on u_dut3: 0x400 + 0x800 (signed 1024 > -2048)
        req1_valid = 1; req1_a = 12'h400; req1_b = 12'h800; req1_sel = 4'b0100;
        #1;
        chk("h3b_r1rdy", 32'(req1_ready_3), 1);
        tick();
        req1_valid = 0;
        tick(); tick(); tick();
        chk("h3b_res", 32'(rsp_result_3), 12'hC00);
        chk("h3b_gt",  32'(rsp_agrtb_3), 1);
        chk("h3b_id",  32'(rsp_id_3), 1);
        tick();

        // Reset during SETTLE drops the op
        req0_valid = 1; req0_a = 12'h055; req0_b = 12'h000; req0_sel = 4'b0011;
        tick();
        req0_valid = 0;
        tick();
        chk("mid_busy_pre", 32'(busy_3), 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_busy",  32'(busy_3), 0);
        chk("mid_alu_a", 32'(alu_a_3), 0);
        chk("mid_rspv",  32'(rsp_valid_3), 0);
        chk("mid_ops",   32'(ops_done_3), 0);
        chk("mid_res",   32'(rsp_result_3), 0);
        chk("mid_id",    32'(rsp_id_3), 0);
        repeat (4) tick();
        chk("mid_no_rsp", 32'(rsp_valid_3), 0);
        chk("mid_idle",   32'(busy_3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
